// File: rtl/gate_bist.sv
// gate_bist: self-test sequencer for the two-input, seven-output gate block.
// Ports: clk, rst (sync, active-high), start -> a/b stimulus, y (7b) in ->
//   busy, done, pass, fail_mask[6:0], fail_vec[1:0], fail_valid.
module gate_bist #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic [6:0] y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] fail_mask,
    output logic [1:0] fail_vec,
    output logic       fail_valid
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        FINISH
    } state_t;

    localparam logic [7:0] CNT_INIT = 8'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [7:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [6:0] mask_q, mask_d;
    logic [1:0] fvec_q, fvec_d;
    logic       fvld_q, fvld_d;
    logic [6:0] exp_y;
    logic [6:0] mm;

    // Truth table bits: {XNOR,NOR,XOR,NAND,NOTa,OR,AND}
    always_comb begin
        exp_y = 7'h00;
        unique case (vec_q)
            2'b00: exp_y = 7'h6C;
            2'b01: exp_y = 7'h1E;
            2'b10: exp_y = 7'h1A;
            2'b11: exp_y = 7'h43;
        endcase
    end

    assign mm = y ^ exp_y;

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        mask_d  = mask_q;
        fvec_d  = fvec_q;
        fvld_d  = fvld_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    vec_d   = 2'b00;
                    mask_d  = 7'h00;
                    fvld_d  = 1'b0;
                    fvec_d  = 2'b00;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == 8'd0) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            CHECK: begin
                mask_d = mask_q | mm;
                // Only the first failing vector is recorded.
                if (mm != 7'h00 && !fvld_q) begin
                    fvec_d = vec_q;
                    fvld_d = 1'b1;
                end
                if (vec_q == 2'b11) begin
                    // busy drops here so FINISH is not a busy cycle.
                    busy_d  = 1'b0;
                    state_d = FINISH;
                end else begin
                    vec_d   = vec_q + 2'd1;
                    cnt_d   = CNT_INIT;
                    state_d = SETTLE;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = (mask_q == 7'h00);
                vec_d   = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= 2'b00;
            cnt_q   <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            mask_q  <= 7'h00;
            fvec_q  <= 2'b00;
            fvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            mask_q  <= mask_d;
            fvec_q  <= fvec_d;
            fvld_q  <= fvld_d;
        end
    end

    assign a          = vec_q[1];
    assign b          = vec_q[0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_mask  = mask_q;
    assign fail_vec   = fvec_q;
    assign fail_valid = fvld_q;

endmodule

// File: doc/gate_bist.md
Name: gate_bist

Overview:
- Self-test sequencer for the two-input, seven-output logic-gate block.
- Drives the gate block's a/b inputs through all four input vectors and samples its seven outputs against the expected truth table.
- Reports pass/fail, a sticky mask of failing outputs, and the first failing vector.
- Sits beside the gate block as its stimulus/check counterpart: it produces what the gate block consumes and consumes what the gate block produces.

Parameters:
- SETTLE_CYCLES, default 2: cycles held on each vector before sampling; legal range 1..255.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a test run; accepted only in IDLE.
- a  out  1  stimulus to gate block input a.
- b  out  1  stimulus to gate block input b.
- y  in  7  gate block outputs: y[0]=AND, y[1]=OR, y[2]=NOT a, y[3]=NAND, y[4]=XOR, y[5]=NOR, y[6]=XNOR.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse at end of run.
- pass  out  1  1 when the last completed run had no mismatches; held until the next start is accepted.
- fail_mask  out  7  sticky OR of per-bit mismatches over the run.
- fail_vec  out  2  {a,b} of the first vector with any mismatch; valid when fail_valid=1.
- fail_valid  out  1  high once any mismatch is seen in the current/last run.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - a=b=0, busy=0, done=0, pass=0, fail_mask=0, fail_vec=0, fail_valid=0.
  - State IDLE, vector register vec=0, settle counter=0.
- a and b are driven directly from vec: a=vec[1], b=vec[0]. They are registered outputs, with no combinational path from y.
- Expected y[6:0] per {a,b}: 00 -> 7'h6C, 01 -> 7'h1E, 10 -> 7'h1A, 11 -> 7'h43.
- States: IDLE, SETTLE, CHECK, FINISH.
- IDLE:
  - start=1 -> vec=0, fail_mask=0, fail_valid=0, fail_vec=0, pass=0, busy=1, counter=SETTLE_CYCLES-1, go to SETTLE.
  - Otherwise hold all outputs.
- SETTLE: if counter==0 go to CHECK; else decrement counter.
- CHECK:
  - Sample y once. mm = y XOR expected(vec); fail_mask |= mm.
  - If mm!=0 and fail_valid==0: fail_vec=vec, fail_valid=1.
  - If vec==3, go to FINISH. Otherwise vec++, counter=SETTLE_CYCLES-1, go to SETTLE.
- FINISH:
  - done=1 for this cycle only; busy=0; pass=(fail_mask==0 including this run's final CHECK).
  - vec returns to 0, so a=b=0. Go to IDLE.
- Latency: each vector occupies SETTLE_CYCLES+1 cycles. done is high in the cycle 4*(SETTLE_CYCLES+1)+1 edges after the edge that accepted start (13 for the default).
- start while busy=1, or in the FINISH cycle, is ignored (no queuing). It is accepted on the next IDLE cycle.
- Back-to-back runs: start held high continuously produces repeated runs with one IDLE cycle between them. Results clear at each acceptance.
- rst during any state aborts the run: all outputs return to reset values on the next edge and no done pulse is produced.
- y is sampled only in CHECK. Changes on y in SETTLE/IDLE/FINISH have no effect.
- X on y during CHECK is a bench error; the design need not handle it.

Test Plan:
1. Golden gate model on y, SETTLE_CYCLES=2, pulse start -> busy=1 for 12 cycles; done pulses 13 edges after accept; pass=1, fail_mask=0, fail_valid=0; a/b step 00,01,10,11 every 3 cycles.
2. y[2] stuck at 0 -> pass=0, fail_mask=7'h04, fail_vec=2'b00, fail_valid=1.
3. y[4] and y[6] swapped -> fail_mask=7'h50, fail_vec=2'b00; a second start with the golden model -> pass=1, fail_mask=0 (results cleared).
4. y[0] inverted only when a&b -> fail_mask=7'h01, fail_vec=2'b11, done still at 13 edges.
5. Assert rst for one cycle while in CHECK of vector 10 -> next edge all outputs at reset values, no done pulse; a subsequent start runs a full 12-cycle test.
6. Pulse start again at cycles 3 and 12 (FINISH) of a run -> both ignored, a single done pulse; start held high -> runs repeat with a 1-cycle IDLE gap.
